// File: rtl/clock_divider_bank.sv
// Bank of programmable 50%-duty clock dividers with per-channel tick strobes.
// Optional phase-sync input enabled by defining CLOCK_DIVIDER_BANK_PHASE_SYNC_EN.
module clock_divider_bank #(
    parameter int CHANNELS    = 4,
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 1,
    localparam int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] en,
    input  logic                cfg_wr,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [DIV_W-1:0]    cfg_div,
`ifdef CLOCK_DIVIDER_BANK_PHASE_SYNC_EN
    input  logic                sync,
`endif
    output logic                cfg_ack,
    output logic                cfg_err,
    output logic [CHANNELS-1:0] clk_out,
    output logic [CHANNELS-1:0] tick
);

    localparam logic [DIV_W-1:0] DEF_D  = DIV_W'(DEFAULT_DIV);
    localparam logic [CH_W:0]    NUM_CH = (CH_W + 1)'(CHANNELS);

    logic ch_ok;
    logic sync_s;
    logic cfg_ack_q, cfg_ack_d;
    logic cfg_err_q, cfg_err_d;

    // Extra top bit keeps the range check meaningful for power-of-two banks.
    assign ch_ok = {1'b0, cfg_ch} < NUM_CH;

`ifdef CLOCK_DIVIDER_BANK_PHASE_SYNC_EN
    assign sync_s = sync;
`else
    assign sync_s = 1'b0;
`endif

    always_comb begin
        cfg_ack_d = cfg_wr & ch_ok;
        cfg_err_d = cfg_wr & ~ch_ok;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cfg_ack_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            cfg_ack_q <= cfg_ack_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign cfg_ack = cfg_ack_q;
    assign cfg_err = cfg_err_q;

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic [DIV_W-1:0] div_q, div_d;
        logic [DIV_W-1:0] pend_q, pend_d;
        logic             pend_valid_q, pend_valid_d;
        logic             clk_q, clk_d;
        logic             tick_q, tick_d;
        logic             wr_hit;
        logic             wrap;

        assign wr_hit = cfg_wr & ch_ok & (cfg_ch == CH_W'(g));
        assign wrap   = en[g] & (cnt_q == div_q);

        always_comb begin
            cnt_d        = cnt_q;
            div_d        = div_q;
            pend_d       = pend_q;
            pend_valid_d = pend_valid_q;
            clk_d        = clk_q;
            tick_d       = 1'b0;
            if (sync_s) begin
                cnt_d = '0;
                clk_d = 1'b0;
                if (pend_valid_q) begin
                    div_d        = pend_q;
                    pend_valid_d = 1'b0;
                end
            end else if (en[g]) begin
                if (wrap) begin
                    cnt_d  = '0;
                    clk_d  = ~clk_q;
                    tick_d = 1'b1;
                    // New divisor only lands on a period boundary.
                    if (pend_valid_q) begin
                        div_d        = pend_q;
                        pend_valid_d = 1'b0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end else if (pend_valid_q) begin
                div_d        = pend_q;
                pend_valid_d = 1'b0;
                cnt_d        = '0;
            end
            // A write on the applying edge stays pending for the next wrap.
            if (wr_hit) begin
                pend_d       = cfg_div;
                pend_valid_d = 1'b1;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                cnt_q        <= '0;
                div_q        <= DEF_D;
                pend_q       <= '0;
                pend_valid_q <= 1'b0;
                clk_q        <= 1'b0;
                tick_q       <= 1'b0;
            end else begin
                cnt_q        <= cnt_d;
                div_q        <= div_d;
                pend_q       <= pend_d;
                pend_valid_q <= pend_valid_d;
                clk_q        <= clk_d;
                tick_q       <= tick_d;
            end
        end

        assign clk_out[g] = clk_q;
        assign tick[g]    = tick_q;
    end

endmodule

// File: tb/tb_clock_divider_bank.sv
// Randomised and directed bench for clock_divider_bank against a
// remaining-cycles reference model.
module tb_clock_divider_bank;

    localparam int NCH   = 3;
    localparam int DW    = 8;
    localparam int DEF   = 1;
    localparam int CHW   = 2;
    localparam int OW    = 2 * NCH + 2;

    logic           clk;
    logic           rst;
    logic [NCH-1:0] en;
    logic           cfg_wr;
    logic [CHW-1:0] cfg_ch;
    logic [DW-1:0]  cfg_div;
    logic           sync;
    logic           cfg_ack;
    logic           cfg_err;
    logic [NCH-1:0] clk_out;
    logic [NCH-1:0] tick;
    logic [OW-1:0]  obs;

    int n_checks = 0;
    int n_pass   = 0;

    int m_rem [NCH];
    int m_div [NCH];
    int m_pend[NCH];
    bit m_pv  [NCH];
    bit m_clk [NCH];
    bit m_tick[NCH];
    bit m_ack;
    bit m_err;

    clock_divider_bank #(
        .CHANNELS   (NCH),
        .DIV_W      (DW),
        .DEFAULT_DIV(DEF)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .en     (en),
        .cfg_wr (cfg_wr),
        .cfg_ch (cfg_ch),
        .cfg_div(cfg_div),
`ifdef CLOCK_DIVIDER_BANK_PHASE_SYNC_EN
        .sync   (sync),
`endif
        .cfg_ack(cfg_ack),
        .cfg_err(cfg_err),
        .clk_out(clk_out),
        .tick   (tick)
    );

    assign obs = {clk_out, tick, cfg_ack, cfg_err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model tracks cycles left until the next wrap instead of a counter.
    task automatic model_step();
        if (rst) begin
            for (int i = 0; i < NCH; i++) begin
                m_rem[i]  = DEF;
                m_div[i]  = DEF;
                m_pv[i]   = 1'b0;
                m_clk[i]  = 1'b0;
                m_tick[i] = 1'b0;
            end
            m_ack = 1'b0;
            m_err = 1'b0;
            return;
        end
        m_ack = cfg_wr && (int'(cfg_ch) < NCH);
        m_err = cfg_wr && (int'(cfg_ch) >= NCH);
        for (int i = 0; i < NCH; i++) begin
            m_tick[i] = 1'b0;
            if (sync) begin
                m_clk[i] = 1'b0;
                if (m_pv[i]) begin
                    m_div[i] = m_pend[i];
                    m_pv[i]  = 1'b0;
                end
                m_rem[i] = m_div[i];
            end else if (en[i]) begin
                if (m_rem[i] == 0) begin
                    m_tick[i] = 1'b1;
                    m_clk[i]  = !m_clk[i];
                    if (m_pv[i]) begin
                        m_div[i] = m_pend[i];
                        m_pv[i]  = 1'b0;
                    end
                    m_rem[i] = m_div[i];
                end else begin
                    m_rem[i] = m_rem[i] - 1;
                end
            end else if (m_pv[i]) begin
                m_div[i] = m_pend[i];
                m_pv[i]  = 1'b0;
                m_rem[i] = m_div[i];
            end
            if (cfg_wr && int'(cfg_ch) == i) begin
                m_pend[i] = int'(cfg_div);
                m_pv[i]   = 1'b1;
            end
        end
    endtask

    function automatic logic [OW-1:0] model_out();
        logic [OW-1:0] r;
        r = '0;
        for (int i = 0; i < NCH; i++) begin
            r[2 + NCH + i] = m_clk[i];
            r[2 + i]       = m_tick[i];
        end
        r[1] = m_ack;
        r[0] = m_err;
        return r;
    endfunction

    task automatic step();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic write_cfg(input int ch, input int d);
        cfg_wr  = 1'b1;
        cfg_ch  = CHW'(ch);
        cfg_div = DW'(d);
        step();
        cfg_wr  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        en = 3'b111;
        cfg_wr = 1'b1;
        cfg_ch = 2'd0;
        cfg_div = 8'd9;
        step();
        step();
        rst = 1'b0;
        cfg_wr = 1'b0;
        n_checks++;
        if (obs !== '0) $display("FAIL reset_state got %b want %b", obs, {OW{1'b0}});
        else n_pass++;
        for (int k = 1; k <= 12; k++) begin
            step();
            n_checks++;
            if (obs !== model_out())
                $display("FAIL reset_run k=%0d got %b want %b", k, obs, model_out());
            else n_pass++;
            n_checks++;
            if (tick !== ((k % 2 == 0) ? 3'b111 : 3'b000))
                $display("FAIL reset_tick k=%0d got %b", k, tick);
            else n_pass++;
        end
    endtask

    task automatic test_program_run();
        int ticks;
        int highs;
        ticks = 0;
        highs = 0;
        en = 3'b011;
        write_cfg(2, 4);
        n_checks++;
        if (cfg_ack !== 1'b1 || cfg_err !== 1'b0)
            $display("FAIL prog_ack got %b%b want 10", cfg_ack, cfg_err);
        else n_pass++;
        step();
        en = 3'b111;
        for (int k = 1; k <= 30; k++) begin
            step();
            n_checks++;
            if (obs !== model_out())
                $display("FAIL prog_run k=%0d got %b want %b", k, obs, model_out());
            else n_pass++;
            ticks += int'(tick[2]);
            highs += int'(clk_out[2]);
        end
        n_checks++;
        if (ticks !== 6) $display("FAIL prog_ticks got %0d want 6", ticks);
        else n_pass++;
        n_checks++;
        if (highs !== 15) $display("FAIL prog_duty got %0d want 15", highs);
        else n_pass++;
    endtask

    task automatic test_glitch_free();
        int first;
        int second;
        first = -1;
        second = -1;
        en = 3'b110;
        write_cfg(0, 7);
        step();
        en = 3'b111;
        step();
        step();
        step();
        write_cfg(0, 1);
        for (int k = 1; k <= 12; k++) begin
            step();
            n_checks++;
            if (obs !== model_out())
                $display("FAIL glitch_run k=%0d got %b want %b", k, obs, model_out());
            else n_pass++;
            if (tick[0] && first < 0) first = k;
            else if (tick[0] && second < 0) second = k;
        end
        n_checks++;
        if (first !== 4 || second !== 6)
            $display("FAIL glitch_ticks got %0d,%0d want 4,6", first, second);
        else n_pass++;
    endtask

    task automatic test_enable_pause();
        en = 3'b101;
        write_cfg(1, 3);
        step();
        en = 3'b111;
        step();
        step();
        en = 3'b101;
        for (int k = 1; k <= 6; k++) begin
            step();
            n_checks++;
            if (obs !== model_out() || tick[1] !== 1'b0)
                $display("FAIL pause_hold k=%0d got %b want %b", k, obs, model_out());
            else n_pass++;
        end
        en = 3'b111;
        step();
        n_checks++;
        if (tick[1] !== 1'b0) $display("FAIL pause_resume1 got %b want 0", tick[1]);
        else n_pass++;
        step();
        n_checks++;
        if (tick[1] !== 1'b1) $display("FAIL pause_resume2 got %b want 1", tick[1]);
        else n_pass++;
    endtask

    task automatic test_bad_channel_overwrite();
        en = 3'b111;
        write_cfg(3, 0);
        n_checks++;
        if (cfg_err !== 1'b1 || cfg_ack !== 1'b0)
            $display("FAIL bad_ch got ack=%b err=%b want ack=0 err=1", cfg_ack, cfg_err);
        else n_pass++;
        cfg_wr = 1'b1;
        cfg_ch = 2'd0;
        cfg_div = 8'd5;
        step();
        cfg_div = 8'd2;
        n_checks++;
        if (cfg_ack !== 1'b1) $display("FAIL ovw_ack1 got %b want 1", cfg_ack);
        else n_pass++;
        step();
        cfg_wr = 1'b0;
        n_checks++;
        if (cfg_ack !== 1'b1) $display("FAIL ovw_ack2 got %b want 1", cfg_ack);
        else n_pass++;
        for (int k = 1; k <= 20; k++) begin
            step();
            n_checks++;
            if (obs !== model_out())
                $display("FAIL ovw_run k=%0d got %b want %b", k, obs, model_out());
            else n_pass++;
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            if ($urandom_range(0, 7) == 0) en = NCH'($urandom);
            cfg_wr = ($urandom_range(0, 2) == 0);
            cfg_ch = CHW'($urandom_range(0, 3));
            cfg_div = ($urandom_range(0, 15) == 0) ? 8'd255 : DW'($urandom_range(0, 5));
            step();
            n_checks++;
            if (obs !== model_out())
                $display("FAIL random k=%0d got %b want %b", k, obs, model_out());
            else n_pass++;
        end
        cfg_wr = 1'b0;
    endtask

    task automatic test_reset_mid();
        en = 3'b111;
        write_cfg(1, 6);
        step();
        rst = 1'b1;
        cfg_wr = 1'b1;
        cfg_ch = 2'd0;
        cfg_div = 8'd3;
        step();
        rst = 1'b0;
        cfg_wr = 1'b0;
        n_checks++;
        if (obs !== '0) $display("FAIL rstmid_state got %b want 0", obs);
        else n_pass++;
        for (int k = 1; k <= 12; k++) begin
            step();
            n_checks++;
            if (obs !== model_out() || tick !== ((k % 2 == 0) ? 3'b111 : 3'b000))
                $display("FAIL rstmid_run k=%0d got %b want %b", k, obs, model_out());
            else n_pass++;
        end
    endtask

`ifdef CLOCK_DIVIDER_BANK_PHASE_SYNC_EN
    task automatic test_sync();
        en = 3'b000;
        write_cfg(0, 2);
        write_cfg(1, 5);
        step();
        en = 3'b111;
        for (int k = 0; k < 4; k++) step();
        write_cfg(2, 3);
        sync = 1'b1;
        step();
        sync = 1'b0;
        n_checks++;
        if (clk_out !== 3'b000 || tick !== 3'b000)
            $display("FAIL sync_state got clk=%b tick=%b want 000", clk_out, tick);
        else n_pass++;
        for (int k = 1; k <= 30; k++) begin
            step();
            n_checks++;
            if (obs !== model_out())
                $display("FAIL sync_run k=%0d got %b want %b", k, obs, model_out());
            else n_pass++;
        end
    endtask
`endif

    initial begin
        rst = 1'b1;
        en = '0;
        cfg_wr = 1'b0;
        cfg_ch = '0;
        cfg_div = '0;
        sync = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            m_pend[i] = 0;
            m_pv[i] = 1'b0;
        end
        test_reset();
        test_program_run();
        test_glitch_free();
        test_enable_pause();
        test_bad_channel_overwrite();
        test_random();
        test_reset_mid();
`ifdef CLOCK_DIVIDER_BANK_PHASE_SYNC_EN
        test_sync();
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/clock_divider_bank.md
Name: clock_divider_bank

Overview:
- Parametrised successor to the catalog's single clock element.
- Generates CHANNELS independent, programmable, 50%-duty divided clocks from one system clock.
- Each channel also produces a one-cycle tick strobe, for use as a clock enable by downstream catalog elements (counters, timers, UART baud).
- Divisors are reprogrammed at runtime through a shared config port with glitch-free, wrap-aligned update.

Parameters:
- CHANNELS, 4: number of independent divider channels (1..16).
- DIV_W, 8: width of each divisor register.
- DEFAULT_DIV, 1: divisor value loaded into every channel at reset; must fit in DIV_W bits.

Ports:
- clk  input  1: system clock; all logic on rising edge.
- rst  input  1: synchronous, active-high reset.
- en  input  CHANNELS: per-channel run enable.
- cfg_wr  input  1: config write strobe, sampled each rising edge.
- cfg_ch  input  max(1,$clog2(CHANNELS)): target channel index.
- cfg_div  input  DIV_W: new divisor value D.
- cfg_ack  output  1: one-cycle pulse, write accepted.
- cfg_err  output  1: one-cycle pulse, write rejected because cfg_ch >= CHANNELS.
- clk_out  output  CHANNELS: divided clocks, registered.
- tick  output  CHANNELS: one-cycle wrap strobe per channel, registered.

Behaviour:
- Reset (rst=1 at an edge) sets, for all channels:
  - cnt=0, div=DEFAULT_DIV, pend_valid=0
  - clk_out=0, tick=0, cfg_ack=0, cfg_err=0
- Reset overrides all other inputs, including a concurrent cfg_wr. Reset mid-count discards pending writes.
- Per channel with divisor D, at each edge with en[i]=1:
  - if cnt==D: cnt<=0, clk_out[i] toggles, tick[i]<=1.
  - else: cnt<=cnt+1, tick[i]<=0.
- Resulting timing:
  - clk_out period = 2*(D+1) cycles, 50% duty.
  - tick period = D+1 cycles.
  - D=0: tick held high every cycle; clk_out = clk/2.
- Counter is DIV_W bits and never exceeds D. D = 2^DIV_W-1 gives the maximum period 2^(DIV_W+1).
- en[i]=0: cnt and clk_out[i] hold their values; tick[i]<=0. When en[i] returns to 1, counting resumes from the held cnt, with no phase reset.
- Config write, cfg_wr=1 at an edge:
  - cfg_ch < CHANNELS: cfg_div is latched into pend[cfg_ch] and pend_valid is set. cfg_ack=1 in the following cycle.
  - cfg_ch >= CHANNELS: state unchanged; cfg_err=1 in the following cycle.
- Pending divisor apply:
  - If en[i]=1: div<=pend, and pend_valid clears, on the same edge where cnt wraps (cnt==D under the old D). The old period always completes, so there are no runt pulses.
  - If en[i]=0: the pending value is applied on the next edge; cnt<=0; clk_out held.
- A second write to the same channel before apply overwrites pend. Last write wins; an ack is issued for each write.
- A write arriving on the same edge as a wrap is not applied on that edge. It is applied at the next wrap.
- Writes on consecutive cycles are all accepted. There is no back-pressure.
- If D is written smaller than the current cnt, this is harmless, because apply happens only at wrap (cnt=0 afterwards).

Optional Feature:
- Macro: CLOCK_DIVIDER_BANK_PHASE_SYNC_EN
- Defined:
  - Adds input port sync (1 bit).
  - On an edge with sync=1 and rst=0, every channel sets cnt<=0 and clk_out<=0, applies any pending divisor immediately, and sets tick<=0. This happens regardless of en.
  - All channels are phase-aligned on the following cycle.
  - sync has priority over a same-cycle wrap. It has lower priority than rst.
- Not defined: no sync port; channels align only via reset.

Test Plan:
- Reset alignment: rst high 2 cycles, en=4'b1111, DEFAULT_DIV=1 -> all clk_out toggle every 2 cycles (period 4), tick every 2nd cycle, all channels in phase; cfg_ack=cfg_err=0.
- Program and run: write ch2 D=4 while ch2 disabled, then en[2]=1 -> cfg_ack pulse 1 cycle after write; tick[2] every 5 cycles; clk_out[2] period 10, high 5 / low 5.
- Glitch-free update: ch0 running D=7; write D=1 at cnt=3 -> old period finishes (tick at cnt=7); the next periods are 2-cycle tick / 4-cycle clk_out, with no shortened high or low phase.
- Enable pause: ch1 D=3 at cnt=2; en[1]=0 for 6 cycles -> clk_out[1] frozen, tick[1]=0; re-enable -> next tick exactly 2 cycles later.
- Bad channel and overwrite: CHANNELS=3, write cfg_ch=3 -> cfg_err pulse, no divisor change. Two back-to-back writes to ch0 (D=5 then D=2) -> two acks, and D=2 takes effect at the next wrap.
- Reset mid-operation (plus, with CLOCK_DIVIDER_BANK_PHASE_SYNC_EN, sync pulse with channels at D=2 and D=5 mid-count): all clk_out go to 0 the next cycle, pending values are dropped (reset) or applied (sync), and counting restarts aligned.
